// File: rtl/reg_file.sv
// 8x32 register file with two bypassed combinational read ports, one WB write port,
// and an integrated return-address stack whose popped top appears on read port 1.
module reg_file #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned PC_W        = 8,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WB_regwrite,
  input  logic              ID_push,
  input  logic              ID_pop,
  input  logic [PC_W-1:0]   stack_pc,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] ws,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] ID_rd1,
  output logic [DATA_W-1:0] ID_rd2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned SP_W     = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SIDX_W   = $clog2(STACK_DEPTH);

  logic [DATA_W-1:0] regs_q  [NUM_REGS];
  logic [DATA_W-1:0] regs_d  [NUM_REGS];
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];
  logic [PC_W-1:0]   stack_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;

  logic              stack_empty_c;
  logic              stack_full_c;
  logic              pop_active_c;
  logic [PC_W-1:0]   stack_top_c;

  assign stack_empty_c = (sp_q == '0);
  assign stack_full_c  = (sp_q == SP_W'(STACK_DEPTH));
  // Push wins over a simultaneous pop; the pop is then dropped entirely.
  assign pop_active_c  = ID_pop && !ID_push;
  assign stack_top_c   = stack_q[SIDX_W'(sp_q - SP_W'(1))];

  // Next-state for register array and return stack
  always_comb begin
    regs_d  = regs_q;
    stack_d = stack_q;
    sp_d    = sp_q;
    if (WB_regwrite) begin
      regs_d[ws] = wd;
    end
    if (ID_push) begin
      if (!stack_full_c) begin
        stack_d[SIDX_W'(sp_q)] = stack_pc;
        sp_d                   = sp_q + SP_W'(1);
      end
    end else if (ID_pop && !stack_empty_c) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
      sp_q <= '0;
    end else begin
      regs_q  <= regs_d;
      stack_q <= stack_d;
      sp_q    <= sp_d;
    end
  end

  // Read ports with WB bypass; port 1 is overridden by an active pop
  always_comb begin
    ID_rd1 = '0;
    ID_rd2 = '0;
    if (reset) begin
      ID_rd2 = (WB_regwrite && (ws == rs2)) ? wd : regs_q[rs2];
      if (pop_active_c) begin
        ID_rd1 = stack_empty_c ? '0 : DATA_W'(stack_top_c);
      end else begin
        ID_rd1 = (WB_regwrite && (ws == rs1)) ? wd : regs_q[rs1];
      end
    end
  end

`ifndef SYNTHESIS
  task automatic print_register_values();
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      $display("reg[%0d] = 0x%08h", i, regs_q[i]);
    end
  endtask
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file: register read/write with bypass,
// return-stack push/pop corners, and asynchronous reset mid-operation.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        WB_regwrite;
  logic        ID_push;
  logic        ID_pop;
  logic [7:0]  stack_pc;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [2:0]  ws;
  logic [31:0] wd;
  logic [31:0] ID_rd1;
  logic [31:0] ID_rd2;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        we;
    logic        push;
    logic        pop;
    logic [7:0]  pc;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  ws;
    logic [31:0] wd;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    int          exp_sp;
  } vec_t;

  vec_t vecs[$];

  reg_file dut (
    .clk         (clk),
    .reset       (reset),
    .WB_regwrite (WB_regwrite),
    .ID_push     (ID_push),
    .ID_pop      (ID_pop),
    .stack_pc    (stack_pc),
    .rs1         (rs1),
    .rs2         (rs2),
    .ws          (ws),
    .wd          (wd),
    .ID_rd1      (ID_rd1),
    .ID_rd2      (ID_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic push, input logic pop, input logic [7:0] pc,
                       input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] w,
                       input logic [31:0] d);
    WB_regwrite = we;
    ID_push     = push;
    ID_pop      = pop;
    stack_pc    = pc;
    rs1         = r1;
    rs2         = r2;
    ws          = w;
    wd          = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held for two cycles
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd1, 3'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset rd1", ID_rd1, 32'h0);
    check("reset rd2", ID_rd2, 32'h0);
    reset = 1'b1;
    #1;
    check("reset sp", 32'(dut.sp_q), 32'd0);

    //                we    push  pop   pc     rs1   rs2   ws    wd            rd1           rd2           sp
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd1, 3'd1, 32'd25,       32'h0,        32'd25,       0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0, 3'd0, 32'h0,        32'd25,       32'h0,        0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'd7, 3'd7, 3'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 3'd7, 3'd2, 32'h1234,     32'd25,       32'hDEADBEEF, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd35,  3'd2, 3'd1, 3'd0, 32'h0,        32'h1234,     32'd25,       1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd2, 3'd0, 32'h0,        32'd35,       32'h1234,     0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd1, 3'd0, 32'h0,        32'h0,        32'd25,       0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h5A,  3'd7, 3'd2, 3'd0, 32'h0,        32'hDEADBEEF, 32'h1234,     1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 3'd1, 3'd1, 3'd1, 32'h99,       32'h5A,       32'h99,       0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0, 3'd0, 32'h0,        32'h99,       32'h0,        0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd7, 3'd7, 3'd0, 32'h0,        32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h77,  3'd1, 3'd2, 3'd0, 32'h0,        32'h99,       32'h1234,     1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0, 3'd0, 32'h0,        32'h77,       32'h0,        0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd3, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0});

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].push, vecs[i].pop, vecs[i].pc,
            vecs[i].rs1, vecs[i].rs2, vecs[i].ws, vecs[i].wd);
      @(negedge clk);
      check($sformatf("vec%0d rd1", i), ID_rd1, vecs[i].exp_rd1);
      check($sformatf("vec%0d rd2", i), ID_rd2, vecs[i].exp_rd2);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d sp", i), 32'(dut.sp_q), 32'(vecs[i].exp_sp));
    end

    // Overfill: 17 pushes into a 16-deep stack, the last must be dropped
    for (int k = 1; k <= 17; k++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(k), 3'd0, 3'd0, 3'd0, 32'h0);
      @(posedge clk);
      #1;
    end
    check("full sp", 32'(dut.sp_q), 32'd16);
    for (int k = 16; k >= 1; k--) begin
      drive(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd7, 3'd0, 32'h0);
      @(negedge clk);
      check($sformatf("pop%0d rd1", k), ID_rd1, 32'(k));
      check($sformatf("pop%0d rd2", k), ID_rd2, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      check($sformatf("pop%0d sp", k), 32'(dut.sp_q), 32'(k - 1));
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0, 3'd0, 32'h0);
    @(negedge clk);
    check("empty pop rd1", ID_rd1, 32'h0);
    @(posedge clk);
    #1;
    check("empty pop sp", 32'(dut.sp_q), 32'd0);

    // Asynchronous reset between edges after writes and pushes
    drive(1'b1, 1'b1, 1'b0, 8'hAB, 3'd0, 3'd0, 3'd5, 32'h5555AAAA);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 8'hCD, 3'd0, 3'd0, 3'd6, 32'h0BADF00D);
    @(posedge clk);
    #1;
    idle();
    rs1 = 3'd5;
    rs2 = 3'd6;
    #1;
    check("pre-reset rd1", ID_rd1, 32'h5555AAAA);
    check("pre-reset rd2", ID_rd2, 32'h0BADF00D);
    check("pre-reset sp", 32'(dut.sp_q), 32'd2);
    reset = 1'b0;
    #1;
    check("async rd1", ID_rd1, 32'h0);
    check("async rd2", ID_rd2, 32'h0);
    check("async sp", 32'(dut.sp_q), 32'd0);
    dut.print_register_values();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int r = 0; r < 8; r++) begin
      rs1 = 3'(r);
      rs2 = 3'(7 - r);
      #1;
      check($sformatf("post-reset reg%0d", r), ID_rd1, 32'h0);
      check($sformatf("post-reset reg%0d", 7 - r), ID_rd2, 32'h0);
    end
    ID_pop = 1'b1;
    #1;
    check("post-reset pop rd1", ID_rd1, 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
